wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Trace capture buffer that sits directly downstream of the CPU's writeback debug port (debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata).
- Records every register-file write event into a first-word-fall-through FIFO.
- Drains the FIFO over a valid/ready port to a consumer (UART dumper or bench scoreboard).
- Counts total, dropped and sticky-overflow events so lost trace is always detectable.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- PTR_W, 4, log2(DEPTH); pointer width.
- CNT_W, 16, width of the dropped-event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- cap_en  input  1  capture enable; when low, writeback events are ignored and not counted.
- clr  input  1  synchronous flush of the FIFO and all counters.
- wb_pc  input  32  writeback PC from CPU.
- wb_wen  input  1  writeback register-file write enable from CPU.
- wb_wnum  input  5  writeback register number.
- wb_wdata  input  32  writeback data.
- trace_valid  output  1  head entry is available.
- trace_ready  input  1  consumer accepts the head entry.
- trace_pc  output  32  head entry PC.
- trace_wnum  output  5  head entry register number.
- trace_wdata  output  32  head entry data.
- fifo_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky; set when any event is dropped.
- drop_cnt  output  CNT_W  number of dropped events; saturating.
- event_cnt  output  32  number of events seen (accepted plus dropped); wraps modulo 2^32.

Behaviour:
- Reset (resetn low, asynchronous): pointers, fifo_count, overflow, drop_cnt and event_cnt are 0; trace_valid is 0; fifo_full is 0. trace_pc, trace_wnum and trace_wdata read 0 while empty.
- Event: ev = cap_en & wb_wen & (wb_wnum != 0). Events with wnum 0 are discarded and not counted.
- Pop: pop = trace_valid & trace_ready.
- Push: push = ev & (~fifo_full | pop). When full, a push is accepted in the same cycle as a pop; occupancy stays at DEPTH.
- Drop: drop = ev & fifo_full & ~pop. On a drop, overflow is set to 1 and drop_cnt increments, saturating at 2^CNT_W-1. The FIFO contents are unchanged.
- event_cnt increments by 1 on every ev, whether accepted or dropped.
- FWFT output: trace_* are driven from the head entry, combinationally from storage.
- Write latency: an entry pushed at edge N is visible with trace_valid=1 after edge N. There is no same-cycle bypass from wb_* to trace_*.
- Ordering: entries are strictly in push order. Pointers wrap modulo DEPTH, with an extra occupancy bit distinguishing full from empty.
- Simultaneous push and pop when empty cannot occur, because trace_valid=0 means no pop.
- Simultaneous push and pop when partially full: count is unchanged, and both pointers advance.
- clr: synchronous and highest priority. When high, pointers, count, overflow, drop_cnt and event_cnt go to 0 on the edge, and any push or drop in that cycle is discarded.
- Stability: while trace_valid=1 and trace_ready=0, trace_* stay constant.
- Mid-operation reset: asserting resetn low clears everything asynchronously, and output drops immediately. After release, no stale entry reappears.
- Storage: a register array of DEPTH x 69 bits (32 + 5 + 32). No RAM inference is required.

Test Plan:
- Reset, then drive one event wb_pc=0xBFC00000, wnum=5, wdata=0x12345678 with trace_ready=0 -> after the edge: trace_valid=1, trace_pc=0xBFC00000, trace_wnum=5, trace_wdata=0x12345678, fifo_count=1, event_cnt=1.
- Push 16 events (pc=4*i, wdata=i) with ready=0, then a 17th -> fifo_full=1, drop_cnt=1, overflow=1, event_cnt=17. Then drain with ready=1 -> wdata sequence 0..15 in order, trace_valid=0 after the 16th pop.
- FIFO full with continuous events and ready=1 every cycle -> no drops, fifo_count stays 16, popped order matches pushed order across pointer wrap (at least 40 events).
- Events with wnum=0, and events with cap_en=0 -> no push, fifo_count=0, event_cnt unchanged.
- With 3 entries held, overflow=1 and drop_cnt=2, assert clr in the same cycle as an event -> next cycle: fifo_count=0, trace_valid=0, overflow=0, drop_cnt=0, event_cnt=0.
- With 5 entries held, pulse resetn low mid-cycle (asynchronous) -> trace_valid falls before the next clk edge. After release, the first new event is at the head, not a stale entry.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: first-word-fall-through FIFO of register-file write events,
// plus dropped, total and sticky-overflow bookkeeping so lost trace is always visible.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cap_en,
  input  logic              clr,
  input  logic [31:0]       wb_pc,
  input  logic              wb_wen,
  input  logic [4:0]        wb_wnum,
  input  logic [31:0]       wb_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic [4:0]        trace_wnum,
  output logic [31:0]       trace_wdata,
  output logic [PTR_W:0]    fifo_count,
  output logic              fifo_full,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [31:0]       event_cnt
);

  localparam int ENTRY_W = 32 + 5 + 32;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               overflow_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;
  logic [31:0]        event_cnt_reg;

  logic               ev;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               not_empty;
  logic [ENTRY_W-1:0] head;

  assign full      = (count_reg == FULL_CNT);
  assign not_empty = (count_reg != '0);
  assign ev        = cap_en & wb_wen & (wb_wnum != 5'd0);
  assign pop       = not_empty & trace_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push      = ev & (~full | pop);
  assign drop      = ev & full & ~pop;

  // Storage is not reset; outputs are masked while empty so stale data never shows.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_reg[wr_ptr_reg] <= {wb_pc, wb_wnum, wb_wdata};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      drop_cnt_reg  <= '0;
      event_cnt_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      drop_cnt_reg  <= '0;
      event_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
      if (ev) event_cnt_reg <= event_cnt_reg + 32'd1;
    end
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign trace_valid = not_empty;
  assign trace_pc    = not_empty ? head[68:37] : 32'd0;
  assign trace_wnum  = not_empty ? head[36:32] : 5'd0;
  assign trace_wdata = not_empty ? head[31:0]  : 32'd0;
  assign fifo_count  = count_reg;
  assign fifo_full   = full;
  assign overflow    = overflow_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign event_cnt   = event_cnt_reg;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: a queue scoreboard models FIFO contents
// and counters; each scenario task compares DUT outputs against it inline.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  logic              clk;
  logic              resetn;
  logic              cap_en;
  logic              clr;
  logic [31:0]       wb_pc;
  logic              wb_wen;
  logic [4:0]        wb_wnum;
  logic [31:0]       wb_wdata;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [4:0]        trace_wnum;
  logic [31:0]       trace_wdata;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_full;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [31:0]       event_cnt;

  int   n_cmp;
  int   n_err;
  ent_t q[$];
  int   exp_event;
  int   exp_drop;
  logic exp_ovf;

  wb_trace_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .cap_en(cap_en), .clr(clr),
    .wb_pc(wb_pc), .wb_wen(wb_wen), .wb_wnum(wb_wnum), .wb_wdata(wb_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
    .drop_cnt(drop_cnt), .event_cnt(event_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_wen = 1'b0; wb_wnum = 5'd0; wb_pc = 32'd0; wb_wdata = 32'd0;
  endtask

  task automatic drive_ev(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
    wb_wen = 1'b1; wb_pc = pc; wb_wnum = wnum; wb_wdata = wdata;
  endtask

  // Model update for an event driven this cycle, applied after any modelled pop.
  task automatic model_event(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
    ent_t e;
    e.pc = pc; e.wnum = wnum; e.wdata = wdata;
    exp_event++;
    if (q.size() < DEPTH) q.push_back(e);
    else begin
      exp_ovf = 1'b1;
      if (exp_drop < (1 << CNT_W) - 1) exp_drop++;
    end
  endtask

  task automatic do_clr();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q.delete();
    exp_event = 0; exp_drop = 0; exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cap_en = 1'b1; clr = 1'b0; trace_ready = 1'b0;
    idle_inputs();
    #12;
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", trace_valid); end
    @(negedge clk); resetn = 1'b1;
    tick();
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (fifo_full !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: got full=%0b ovf=%0b want 0/0", fifo_full, overflow); end
    n_cmp++; if (drop_cnt !== '0 || event_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnts: got drop=%0d ev=%0d want 0/0", drop_cnt, event_cnt); end
    n_cmp++; if ({trace_pc, trace_wnum, trace_wdata} !== 69'd0) begin n_err++; $display("FAIL reset_data: got pc=%h wnum=%0d wdata=%h want 0", trace_pc, trace_wnum, trace_wdata); end
    q.delete(); exp_event = 0; exp_drop = 0; exp_ovf = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single();
    trace_ready = 1'b0;
    drive_ev(32'hBFC0_0000, 5'd5, 32'h1234_5678);
    model_event(32'hBFC0_0000, 5'd5, 32'h1234_5678);
    tick();
    idle_inputs();
    n_cmp++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", trace_valid); end
    n_cmp++; if (trace_pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL single_pc: got %h want bfc00000", trace_pc); end
    n_cmp++; if (trace_wnum !== 5'd5) begin n_err++; $display("FAIL single_wnum: got %0d want 5", trace_wnum); end
    n_cmp++; if (trace_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL single_wdata: got %h want 12345678", trace_wdata); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    n_cmp++; if (event_cnt !== 32'd1) begin n_err++; $display("FAIL single_event: got %0d want 1", event_cnt); end
    $display("single event pc=%h wnum=%0d wdata=%h", trace_pc, trace_wnum, trace_wdata);
    trace_ready = 1'b1; void'(q.pop_front());
    tick();
    trace_ready = 1'b0;
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL single_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_overflow_drain();
    int pops;
    ent_t e;
    do_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_ev(32'(4 * i), 5'((i % 31) + 1), 32'(i));
      model_event(32'(4 * i), 5'((i % 31) + 1), 32'(i));
      tick();
    end
    idle_inputs();
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %0b want 1", fifo_full); end
    n_cmp++; if (drop_cnt !== CNT_W'(exp_drop)) begin n_err++; $display("FAIL ovf_drop: got %0d want %0d", drop_cnt, exp_drop); end
    n_cmp++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL ovf_sticky: got %0b want %0b", overflow, exp_ovf); end
    n_cmp++; if (event_cnt !== 32'(exp_event)) begin n_err++; $display("FAIL ovf_event: got %0d want %0d", event_cnt, exp_event); end
    tick();
    n_cmp++; if (trace_wdata !== q[0].wdata) begin n_err++; $display("FAIL ovf_hold: got %h want %h", trace_wdata, q[0].wdata); end
    trace_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < DEPTH + 4 && q.size() != 0; c++) begin
      e = q.pop_front();
      n_cmp++;
      if (trace_valid !== 1'b1 || trace_pc !== e.pc || trace_wnum !== e.wnum || trace_wdata !== e.wdata) begin
        n_err++; $display("FAIL drain_entry: got v=%0b pc=%h wnum=%0d wdata=%h want pc=%h wnum=%0d wdata=%h",
                          trace_valid, trace_pc, trace_wnum, trace_wdata, e.pc, e.wnum, e.wdata);
      end
      $display("pop pc=%h wnum=%0d wdata=%h", trace_pc, trace_wnum, trace_wdata);
      pops++;
      tick();
    end
    trace_ready = 1'b0;
    n_cmp++; if (pops !== DEPTH) begin n_err++; $display("FAIL drain_pops: got %0d want %0d", pops, DEPTH); end
    n_cmp++; if (trace_valid !== 1'b0 || fifo_count !== '0) begin n_err++; $display("FAIL drain_empty: got v=%0b cnt=%0d want 0/0", trace_valid, fifo_count); end
  endtask

  task automatic test_stream_wrap();
    ent_t e;
    logic [31:0] pc, wd;
    logic [4:0]  wn;
    do_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_ev(32'h8000_0000 + 32'(4 * i), 5'd1 + 5'(i), 32'hA000 + 32'(i));
      model_event(32'h8000_0000 + 32'(4 * i), 5'd1 + 5'(i), 32'hA000 + 32'(i));
      tick();
    end
    trace_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      pc = $urandom; wd = $urandom; wn = 5'($urandom_range(1, 31));
      drive_ev(pc, wn, wd);
      e = q.pop_front();
      n_cmp++;
      if (trace_valid !== 1'b1 || trace_pc !== e.pc || trace_wnum !== e.wnum || trace_wdata !== e.wdata) begin
        n_err++; $display("FAIL stream_entry: got v=%0b pc=%h wnum=%0d wdata=%h want pc=%h wnum=%0d wdata=%h",
                          trace_valid, trace_pc, trace_wnum, trace_wdata, e.pc, e.wnum, e.wdata);
      end
      $display("stream pop pc=%h wdata=%h", trace_pc, trace_wdata);
      model_event(pc, wn, wd);
      tick();
      n_cmp++; if (fifo_count !== 5'(q.size())) begin n_err++; $display("FAIL stream_count: got %0d want %0d", fifo_count, q.size()); end
    end
    idle_inputs();
    n_cmp++; if (drop_cnt !== '0 || overflow !== 1'b0) begin n_err++; $display("FAIL stream_nodrop: got drop=%0d ovf=%0b want 0/0", drop_cnt, overflow); end
    n_cmp++; if (event_cnt !== 32'(exp_event)) begin n_err++; $display("FAIL stream_event: got %0d want %0d", event_cnt, exp_event); end
    for (int c = 0; c < DEPTH + 4 && q.size() != 0; c++) begin
      e = q.pop_front();
      n_cmp++; if (trace_wdata !== e.wdata) begin n_err++; $display("FAIL stream_tail: got %h want %h", trace_wdata, e.wdata); end
      tick();
    end
    trace_ready = 1'b0;
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty: got %0b want 0", trace_valid); end
  endtask

  task automatic test_filter();
    do_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap_en = 1'b1; drive_ev(32'h100 + 32'(i), 5'd0, 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      cap_en = 1'b0; drive_ev(32'h200 + 32'(i), 5'd7, 32'(i));
      tick();
    end
    cap_en = 1'b1; idle_inputs();
    $display("filter: wnum0 and cap_en=0 events driven");
    n_cmp++; if (fifo_count !== '0 || trace_valid !== 1'b0) begin n_err++; $display("FAIL filter_count: got cnt=%0d v=%0b want 0/0", fifo_count, trace_valid); end
    n_cmp++; if (event_cnt !== 32'd0) begin n_err++; $display("FAIL filter_event: got %0d want 0", event_cnt); end
  endtask

  task automatic test_clr();
    do_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_ev(32'h300 + 32'(4 * i), 5'd3, 32'hC000 + 32'(i));
      model_event(32'h300 + 32'(4 * i), 5'd3, 32'hC000 + 32'(i));
      tick();
    end
    idle_inputs();
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH - 3; i++) begin
      void'(q.pop_front());
      tick();
    end
    trace_ready = 1'b0;
    n_cmp++; if (fifo_count !== 5'd3 || trace_wdata !== q[0].wdata) begin n_err++; $display("FAIL clr_pre: got cnt=%0d wdata=%h want 3/%h", fifo_count, trace_wdata, q[0].wdata); end
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin n_err++; $display("FAIL clr_pre_ovf: got ovf=%0b drop=%0d want 1/2", overflow, drop_cnt); end
    clr = 1'b1;
    drive_ev(32'h999, 5'd9, 32'h999);
    tick();
    clr = 1'b0; idle_inputs();
    q.delete(); exp_event = 0; exp_drop = 0; exp_ovf = 1'b0;
    $display("clr asserted with event");
    n_cmp++; if (fifo_count !== '0 || trace_valid !== 1'b0) begin n_err++; $display("FAIL clr_fifo: got cnt=%0d v=%0b want 0/0", fifo_count, trace_valid); end
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_err++; $display("FAIL clr_ovf: got ovf=%0b drop=%0d want 0/0", overflow, drop_cnt); end
    n_cmp++; if (event_cnt !== 32'd0) begin n_err++; $display("FAIL clr_event: got %0d want 0", event_cnt); end
  endtask

  task automatic test_async_reset();
    do_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_ev(32'h400 + 32'(4 * i), 5'd4, 32'hD000 + 32'(i));
      model_event(32'h400 + 32'(4 * i), 5'd4, 32'hD000 + 32'(i));
      tick();
    end
    idle_inputs();
    n_cmp++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL arst_pre: got %0d want 5", fifo_count); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (trace_valid !== 1'b0 || fifo_count !== '0) begin n_err++; $display("FAIL arst_async: got v=%0b cnt=%0d want 0/0", trace_valid, fifo_count); end
    #2 resetn = 1'b1;
    q.delete(); exp_event = 0; exp_drop = 0; exp_ovf = 1'b0;
    tick();
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale: got %0b want 0", trace_valid); end
    drive_ev(32'h5555_0000, 5'd17, 32'hFEED_BEEF);
    tick();
    idle_inputs();
    $display("post-reset event pc=%h wdata=%h", trace_pc, trace_wdata);
    n_cmp++; if (trace_valid !== 1'b1 || trace_wdata !== 32'hFEED_BEEF || trace_pc !== 32'h5555_0000) begin
      n_err++; $display("FAIL arst_head: got v=%0b pc=%h wdata=%h want 1/55550000/feedbeef", trace_valid, trace_pc, trace_wdata);
    end
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL arst_count: got %0d want 1", fifo_count); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_single();
    test_overflow_drain();
    test_stream_wrap();
    test_filter();
    test_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
